bpd_upd_sched: RTL and testbench
================================

# bpd_upd_sched

Update scheduler for the branch-direction predictor tables (global gshare PHT, local PHT, choice table). It owns the single write port of each table: it sweeps every table to its initial counter value after reset, then buffers retired-branch updates in a small FIFO. It drains one update per cycle, deferring a write that collides with the same-cycle fetch read of the global PHT, with a bounded starvation limit.

## Interface
Parameters:
- GIDX_W, 12, global PHT / choice table index width
- LIDX_W, 10, local PHT index width (LIDX_W ≤ GIDX_W)
- DEPTH, 4, update FIFO entries (power of 2)
- MAX_DEFER, 3, maximum consecutive collision deferrals before a forced write

Ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-high
- ret_valid_i  in  1  retired conditional-branch update offered
- ret_ready_o  out  1  scheduler accepts the update
- ret_gidx_i  in  GIDX_W  global index (pc[13:2] ^ bhr at prediction)
- ret_lidx_i  in  LIDX_W  local history index
- ret_brdir_i  in  1  resolved direction
- ret_ch_we_i  in  1  choice update required (global ≠ local)
- ret_ch_dir_i  in  1  choice update direction
- fetch_rd_valid_i  in  1  fetch is reading the global PHT this cycle
- fetch_rd_gidx_i  in  GIDX_W  fetch read index
- g_we_o / g_widx_o  out  1 / GIDX_W  global PHT write
- l_we_o / l_widx_o  out  1 / LIDX_W  local PHT write
- ch_we_o / ch_widx_o / ch_dir_o  out  1 / GIDX_W / 1  choice table write
- wr_dir_o  out  1  branch direction for the g/l write
- wr_init_o  out  1  write the table's SATCNT_INIT value, ignoring wr_dir_o
- init_done_o  out  1  init sweep complete
- fifo_cnt_o  out  log2(DEPTH)+1  occupancy

## Operation
- FSM states: INIT (entered on reset) and RUN. There are no other transitions; only reset returns the FSM to INIT.
- INIT: counter c runs 0 to 2^GIDX_W-1, one per cycle.
  - Each cycle writes g_we_o=1, g_widx_o=c, ch_we_o=1, ch_widx_o=c, ch_dir_o=0, wr_init_o=1.
  - l_we_o=1 with l_widx_o=c[LIDX_W-1:0] only while c < 2^LIDX_W.
  - After the final index the FSM moves to RUN.
- ret_ready_o = init_done_o & (fifo_cnt_o < DEPTH). There is no pop-through when full.
- Push on ret_valid_i & ret_ready_o. The entry holds {gidx, lidx, brdir, ch_we, ch_dir}.
- RUN pop rules, when the FIFO is non-empty:
  - Collision = fetch_rd_valid_i & (head.gidx == fetch_rd_gidx_i).
  - With no collision, pop.
  - With a collision and defer_cnt < MAX_DEFER, hold and increment defer_cnt.
  - With defer_cnt == MAX_DEFER, pop anyway (forced write).
  - defer_cnt clears on every pop and whenever the FIFO is empty.
- Pop output: g_we_o=1, l_we_o=1, wr_dir_o=head.brdir, wr_init_o=0, ch_we_o=head.ch_we, ch_dir_o=head.ch_dir, ch_widx_o=head.gidx.
- Simultaneous push and pop: the count is unchanged and FIFO order is preserved.

## Timing
- Reset values: every *_we_o=0, all indices 0, wr_dir_o=0, wr_init_o=0, ch_dir_o=0, init_done_o=0, ret_ready_o=0, fifo_cnt_o=0, defer_cnt=0, FSM=INIT.
- All write outputs are registered. The pop/init decision is made in cycle k and the outputs are asserted for exactly one cycle, k+1.
- Init sweep: the first edge after reset release registers index 0. The edge after the index-(2^GIDX_W-1) write deasserts all we, and init_done_o rises at that same edge, 2^GIDX_W+1 edges after release (4097 at defaults).
- Retire latency: a handshake at edge k becomes the head after k. With no collision it pops in cycle k+1, so the write outputs are asserted in cycle k+2.
- Maximum stall per entry: MAX_DEFER cycles.
- Reset mid-operation: the FIFO is discarded, outputs return to reset values, and the sweep restarts at 0.
- Updates offered during INIT are not accepted (ret_ready_o=0).

## Structure
- Shared package bpd_pkg holds:
  - GIDX_W and LIDX_W constants.
  - bpd_upd_t struct {gidx, lidx, brdir, ch_we, ch_dir}.
  - State enum {BPD_INIT, BPD_RUN}.
- Sub-module bpd_upd_fifo: synchronous DEPTH-entry FIFO of bpd_upd_t with push/pop/count/head. The top level holds the FSM, init counter, defer logic and output registers.

## Test plan
- Reset release, no traffic: 4096 consecutive g_we_o/wr_init_o pulses, indices 0..4095. l_we_o is asserted on the first 1024 only. init_done_o rises at edge 4097.
- After init, push gidx=0x0A5, lidx=0x3F, brdir=1, ch_we=1, ch_dir=0: two cycles after the handshake, g_widx_o=0x0A5, l_widx_o=0x3F, wr_dir_o=1, ch_we_o=1, ch_dir_o=0, all for one cycle.
- Push 5 back-to-back updates with fetch_rd_valid_i held colliding with every head: ret_ready_o drops after 4 accepted. Each write is forced after 3 deferrals, and order is preserved.
- Collision for 1 cycle, then fetch_rd_gidx_i changes: the write occurs after 1 deferral and defer_cnt clears.
- Simultaneous push and pop at count 2: fifo_cnt_o stays 2 and the popped entry is the oldest.
- Assert reset at sweep index 2000 and with 3 entries queued: outputs clear, fifo_cnt_o=0, and the sweep restarts at index 0.

Source files
------------

// File: rtl/bpd_pkg.sv
// Shared types and default widths for the branch-direction predictor update path.
package bpd_pkg;

  localparam int GIDX_W = 12;
  localparam int LIDX_W = 10;

  // One retired-branch update waiting for the table write ports.
  typedef struct packed {
    logic [GIDX_W-1:0] gidx;
    logic [LIDX_W-1:0] lidx;
    logic              brdir;
    logic              ch_we;
    logic              ch_dir;
  } bpd_upd_t;

  typedef enum logic [0:0] {
    BPD_INIT = 1'b0,
    BPD_RUN  = 1'b1
  } bpd_state_t;

endpackage

// File: rtl/bpd_upd_fifo.sv
// Small synchronous FIFO of predictor updates; head is visible without popping.
module bpd_upd_fifo
  import bpd_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  bpd_upd_t         din,
  output bpd_upd_t         head,
  output logic [CNT_W-1:0] cnt,
  output logic             empty,
  output logic             full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  bpd_upd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the count.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bpd_upd_sched.sv
// Owns the write ports of the global PHT, local PHT and choice table: sweeps
// them to their init value after reset, then drains buffered retire updates,
// yielding to same-index fetch reads of the global PHT for a bounded time.
//
// state    | meaning
// BPD_INIT | writing init value to index init_cnt of every table
// BPD_RUN  | draining the update FIFO, one write per cycle
module bpd_upd_sched
  import bpd_pkg::*;
#(
  parameter int GIDX_W    = bpd_pkg::GIDX_W,
  parameter int LIDX_W    = bpd_pkg::LIDX_W,
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 3,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ret_valid_i,
  output logic              ret_ready_o,
  input  logic [GIDX_W-1:0] ret_gidx_i,
  input  logic [LIDX_W-1:0] ret_lidx_i,
  input  logic              ret_brdir_i,
  input  logic              ret_ch_we_i,
  input  logic              ret_ch_dir_i,
  input  logic              fetch_rd_valid_i,
  input  logic [GIDX_W-1:0] fetch_rd_gidx_i,
  output logic              g_we_o,
  output logic [GIDX_W-1:0] g_widx_o,
  output logic              l_we_o,
  output logic [LIDX_W-1:0] l_widx_o,
  output logic              ch_we_o,
  output logic [GIDX_W-1:0] ch_widx_o,
  output logic              ch_dir_o,
  output logic              wr_dir_o,
  output logic              wr_init_o,
  output logic              init_done_o,
  output logic [CNT_W-1:0]  fifo_cnt_o
);

  localparam int                DEF_W    = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam logic [DEF_W-1:0]  DEF_MAX  = DEF_W'(MAX_DEFER);
  localparam logic [GIDX_W-1:0] LAST_IDX = '1;

  bpd_state_t        state;
  logic [GIDX_W-1:0] init_cnt;
  logic [DEF_W-1:0]  defer_cnt;
  logic              in_l_range;

  bpd_upd_t          push_data;
  bpd_upd_t          head;
  logic              push;
  logic              pop;
  logic              collide;
  logic              fifo_empty;
  logic              fifo_full;

  // The local PHT is smaller, so only the low part of the sweep touches it.
  assign in_l_range  = (32'(init_cnt) < (32'd1 << LIDX_W));

  assign ret_ready_o = init_done_o & ~fifo_full;
  assign push        = ret_valid_i & ret_ready_o;
  assign push_data   = '{gidx: ret_gidx_i, lidx: ret_lidx_i, brdir: ret_brdir_i,
                         ch_we: ret_ch_we_i, ch_dir: ret_ch_dir_i};

  assign collide     = fetch_rd_valid_i & (head.gidx == fetch_rd_gidx_i);
  assign pop         = (state == BPD_RUN) & ~fifo_empty & (~collide | (defer_cnt == DEF_MAX));

  bpd_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (push_data),
    .head    (head),
    .cnt     (fifo_cnt_o),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Init sweep counter; RUN is left only through reset.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      state    <= BPD_INIT;
      init_cnt <= '0;
    end else if (state == BPD_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_IDX) state <= BPD_RUN;
    end
  end

  // Counts consecutive cycles the head yielded to a colliding fetch read.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      defer_cnt <= '0;
    end else if (fifo_empty || pop) begin
      defer_cnt <= '0;
    end else if ((state == BPD_RUN) && collide) begin
      defer_cnt <= defer_cnt + 1'b1;
    end
  end

  // Registered write ports: one-cycle pulses for either an init or a popped update.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      g_we_o      <= 1'b0;
      g_widx_o    <= '0;
      l_we_o      <= 1'b0;
      l_widx_o    <= '0;
      ch_we_o     <= 1'b0;
      ch_widx_o   <= '0;
      ch_dir_o    <= 1'b0;
      wr_dir_o    <= 1'b0;
      wr_init_o   <= 1'b0;
      init_done_o <= 1'b0;
    end else begin
      g_we_o      <= 1'b0;
      g_widx_o    <= '0;
      l_we_o      <= 1'b0;
      l_widx_o    <= '0;
      ch_we_o     <= 1'b0;
      ch_widx_o   <= '0;
      ch_dir_o    <= 1'b0;
      wr_dir_o    <= 1'b0;
      wr_init_o   <= 1'b0;
      init_done_o <= (state == BPD_RUN);
      if (state == BPD_INIT) begin
        g_we_o    <= 1'b1;
        g_widx_o  <= init_cnt;
        ch_we_o   <= 1'b1;
        ch_widx_o <= init_cnt;
        wr_init_o <= 1'b1;
        l_we_o    <= in_l_range;
        l_widx_o  <= in_l_range ? init_cnt[LIDX_W-1:0] : '0;
      end else if (pop) begin
        g_we_o    <= 1'b1;
        g_widx_o  <= head.gidx;
        l_we_o    <= 1'b1;
        l_widx_o  <= head.lidx;
        wr_dir_o  <= head.brdir;
        ch_we_o   <= head.ch_we;
        ch_widx_o <= head.gidx;
        ch_dir_o  <= head.ch_dir;
      end
    end
  end

endmodule

// File: tb/tb_bpd_upd_sched.sv
// Scoreboard bench for bpd_upd_sched: expected writes are queued at handshake
// and matched against the write ports when they pulse.
module tb_bpd_upd_sched;
  import bpd_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ret_valid_i = 1'b0;
  logic        ret_ready_o;
  logic [11:0] ret_gidx_i = '0;
  logic [9:0]  ret_lidx_i = '0;
  logic        ret_brdir_i = 1'b0;
  logic        ret_ch_we_i = 1'b0;
  logic        ret_ch_dir_i = 1'b0;
  logic        fetch_rd_valid_i = 1'b0;
  logic [11:0] fetch_rd_gidx_i = '0;
  logic        g_we_o;
  logic [11:0] g_widx_o;
  logic        l_we_o;
  logic [9:0]  l_widx_o;
  logic        ch_we_o;
  logic [11:0] ch_widx_o;
  logic        ch_dir_o;
  logic        wr_dir_o;
  logic        wr_init_o;
  logic        init_done_o;
  logic [2:0]  fifo_cnt_o;

  bpd_upd_sched #(
    .GIDX_W(12), .LIDX_W(10), .DEPTH(4), .MAX_DEFER(3)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .ret_valid_i(ret_valid_i), .ret_ready_o(ret_ready_o),
    .ret_gidx_i(ret_gidx_i), .ret_lidx_i(ret_lidx_i), .ret_brdir_i(ret_brdir_i),
    .ret_ch_we_i(ret_ch_we_i), .ret_ch_dir_i(ret_ch_dir_i),
    .fetch_rd_valid_i(fetch_rd_valid_i), .fetch_rd_gidx_i(fetch_rd_gidx_i),
    .g_we_o(g_we_o), .g_widx_o(g_widx_o), .l_we_o(l_we_o), .l_widx_o(l_widx_o),
    .ch_we_o(ch_we_o), .ch_widx_o(ch_widx_o), .ch_dir_o(ch_dir_o),
    .wr_dir_o(wr_dir_o), .wr_init_o(wr_init_o), .init_done_o(init_done_o),
    .fifo_cnt_o(fifo_cnt_o)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    bpd_upd_t u;
    int       wr_edge;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_all();
    return 64'({g_we_o, g_widx_o, l_we_o, l_widx_o, ch_we_o, ch_widx_o, ch_dir_o,
                wr_dir_o, wr_init_o, init_done_o, ret_ready_o, fifo_cnt_o});
  endfunction

  // Indices are only meaningful while their write enable is high.
  function automatic logic [63:0] obs_init();
    return 64'({g_we_o, g_we_o ? g_widx_o : 12'd0, l_we_o, l_we_o ? l_widx_o : 10'd0,
                ch_we_o, ch_we_o ? ch_widx_o : 12'd0, ch_dir_o, wr_init_o,
                init_done_o, ret_ready_o, fifo_cnt_o});
  endfunction

  // Scoreboard: every non-init write must match the oldest outstanding update.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n && g_we_o && !wr_init_o) begin
      if (exp_q.size() == 0) begin
        chk("unexp_wr", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_fields",
            64'({g_widx_o, l_we_o, l_widx_o, wr_dir_o, ch_we_o, ch_we_o ? ch_widx_o : 12'd0, ch_dir_o}),
            64'({e.u.gidx, 1'b1, e.u.lidx, e.u.brdir, e.u.ch_we, e.u.ch_we ? e.u.gidx : 12'd0, e.u.ch_dir}));
        if (e.wr_edge >= 0) chk("wr_edge", 64'(cyc), 64'(e.wr_edge));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [11:0] g, input logic [9:0] l, input logic d,
                      input logic cw, input logic cd, input int lat, output int hs);
    exp_t e;
    int n;
    ret_gidx_i   = g;
    ret_lidx_i   = l;
    ret_brdir_i  = d;
    ret_ch_we_i  = cw;
    ret_ch_dir_i = cd;
    ret_valid_i  = 1'b1;
    n  = 0;
    hs = -1;
    while (!ret_ready_o && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (ret_ready_o) begin
      hs = cyc + 1;
      e.u.gidx   = g;
      e.u.lidx   = l;
      e.u.brdir  = d;
      e.u.ch_we  = cw;
      e.u.ch_dir = cd;
      e.wr_edge  = (lat >= 0) ? hs + lat : -1;
      exp_q.push_back(e);
    end else begin
      chk("send_timeout", 64'(ret_ready_o), 64'd1);
    end
    @(negedge clock);
    ret_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("drain_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("pulse_end", 64'(g_we_o), 64'd0);
  endtask

  // Starts right after reset release at a negedge; offers updates throughout.
  task automatic init_sweep(input int stop);
    logic [11:0] cc;
    logic        lw;
    logic [63:0] ex;
    ret_gidx_i  = 12'hABC;
    ret_lidx_i  = 10'h155;
    ret_valid_i = 1'b1;
    for (int n = 1; n <= stop; n++) begin
      @(negedge clock);
      if (n <= 4096) begin
        cc = 12'(n - 1);
        lw = ((n - 1) < 1024);
        ex = 64'({1'b1, cc, lw, lw ? cc[9:0] : 10'd0, 1'b1, cc, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
      end else begin
        ex = 64'({1'b0, 12'd0, 1'b0, 10'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0});
      end
      chk("init", obs_init(), ex);
      if (n == 4096) ret_valid_i = 1'b0;
    end
    ret_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int h1;

    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst", obs_all(), 64'd0);
    reset_n = 1'b0;
    init_sweep(4097);

    // single update, no collision
    send(12'h0A5, 10'h3F, 1'b1, 1'b1, 1'b0, 1, hs);
    drain();

    // five back-to-back updates all colliding with the fetch read
    fetch_rd_valid_i = 1'b1;
    fetch_rd_gidx_i  = 12'h123;
    h1 = 0;
    for (int i = 1; i <= 5; i++) begin
      send(12'h123, 10'(i), 1'(i), 1'b1, 1'((i >> 1) & 1), -1, hs);
      if (i == 1) h1 = hs;
      exp_q[exp_q.size() - 1].wr_edge = h1 + 4 * i;
      if (i == 4) begin
        chk("full_cnt", 64'(fifo_cnt_o), 64'd4);
        chk("full_ready", 64'(ret_ready_o), 64'd0);
      end
    end
    drain();

    // one deferral, then the fetch moves away; next head starts from zero deferrals
    fetch_rd_gidx_i = 12'h3C3;
    send(12'h3C3, 10'h011, 1'b0, 1'b0, 1'b0, 2, hs);
    @(negedge clock);
    fetch_rd_gidx_i = 12'h3C4;
    send(12'h3C4, 10'h022, 1'b1, 1'b1, 1'b1, 4, hs);
    drain();

    // push and pop in the same cycle at count 2
    fetch_rd_gidx_i = 12'h200;
    send(12'h200, 10'h0A0, 1'b1, 1'b0, 1'b0, 4, hs);
    send(12'h201, 10'h0A1, 1'b0, 1'b1, 1'b1, 4, hs);
    repeat (2) @(negedge clock);
    chk("pp_before", 64'(fifo_cnt_o), 64'd2);
    send(12'h202, 10'h0A2, 1'b1, 1'b1, 1'b0, 2, hs);
    chk("pp_after", 64'(fifo_cnt_o), 64'd2);
    drain();

    // reset with three entries queued
    fetch_rd_gidx_i = 12'h055;
    for (int i = 0; i < 3; i++) send(12'h055, 10'(i + 8), 1'b1, 1'b0, 1'b0, -1, hs);
    chk("q3_cnt", 64'(fifo_cnt_o), 64'd3);
    reset_n = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_queued", obs_all(), 64'd0);
    @(negedge clock);
    fetch_rd_valid_i = 1'b0;
    reset_n = 1'b0;

    // reset in the middle of the sweep, at index 2000
    init_sweep(2001);
    reset_n = 1'b1;
    #1;
    chk("rst_sweep", obs_all(), 64'd0);
    @(negedge clock);
    reset_n = 1'b0;
    init_sweep(4097);

    send(12'hFED, 10'h3FF, 1'b0, 1'b1, 1'b1, 1, hs);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
